// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, valid/ready handshake and flush.
// Optional statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q == StOne) || (state_q == StTwo);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (in_fire) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
          state_d     = StTwo;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush overrides any transfer this cycle; stale payload bits are harmless once invalid.
    if (flush) begin
      state_d = StEmpty;
    end
    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign out_data = main_data_q;
  // Invalid slots present a NOP control word downstream.
  assign out_ctrl = out_valid ? main_ctrl_q : '0;

`ifdef PIPE_STAGE_STATS_EN
  logic [STAT_W-1:0] stall_q, bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + STAT_W'(1);
      end
      if (!out_valid && (bubble_q != '1)) begin
        bubble_q <= bubble_q + STAT_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (handshake, skid, flush, bubble, counters).
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [STAT_W-1:0] stall_cnt;
  logic [STAT_W-1:0] bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .STAT_W(STAT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset state
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_out_ctrl", 64'(out_ctrl), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    step();
    check("rst_hold_valid", 64'(out_valid), 64'h0);
    check("rst_hold_data", 64'(out_data), 64'h0);

    // 2. Full-rate stream, one output per cycle, in order
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 64'(i);
      in_ctrl = 8'(8'h10 + i);
      step();
      check($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'h1);
      check($sformatf("stream_data_%0d", i), 64'(out_data), 64'(i));
      check($sformatf("stream_ctrl_%0d", i), 64'(out_ctrl), 64'(8'h10 + i));
      check($sformatf("stream_ready_%0d", i), 64'(in_ready), 64'h1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", 64'(out_valid), 64'h0);

    // 3. Backpressure fills the skid entry, third word held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    in_ctrl   = 8'h0A;
    step();
    check("bp_a_ready", 64'(in_ready), 64'h1);
    check("bp_a_data", 64'(out_data), 64'hA);
    in_data = 64'hB;
    in_ctrl = 8'h0B;
    step();
    check("bp_b_ready", 64'(in_ready), 64'h0);
    check("bp_b_head", 64'(out_data), 64'hA);
    in_data = 64'hC;
    in_ctrl = 8'h0C;
    step();
    step();
    check("bp_c_blocked", 64'(in_ready), 64'h0);
    check("bp_hold_data", 64'(out_data), 64'hA);
    check("bp_hold_ctrl", 64'(out_ctrl), 64'h0A);
    out_ready = 1'b1;
    step();
    check("bp_out_b", 64'(out_data), 64'hB);
    check("bp_out_b_ready", 64'(in_ready), 64'h1);
    step();
    check("bp_out_c", 64'(out_data), 64'hC);
    check("bp_out_c_valid", 64'(out_valid), 64'h1);
    in_valid = 1'b0;
    step();
    check("bp_empty", 64'(out_valid), 64'h0);

    // 4. Flush in TWO state with a pending input, then in ONE state with in_fire
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    in_ctrl   = 8'h21;
    step();
    in_data = 64'h12;
    in_ctrl = 8'h22;
    step();
    check("fl_two_ready", 64'(in_ready), 64'h0);
    flush   = 1'b1;
    in_data = 64'hD;
    in_ctrl = 8'h2D;
    step();
    check("fl_valid", 64'(out_valid), 64'h0);
    check("fl_ctrl", 64'(out_ctrl), 64'h0);
    check("fl_ready", 64'(in_ready), 64'h1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("fl_d_lost", 64'(out_valid), 64'h0);
    in_valid = 1'b1;
    in_data  = 64'h31;
    in_ctrl  = 8'h41;
    step();
    flush   = 1'b1;
    in_data = 64'h32;
    step();
    check("fl_one_valid", 64'(out_valid), 64'h0);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check("fl_one_dropped", 64'(out_valid), 64'h0);

    // 5. Bubble presents zero control
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    in_ctrl   = 8'hFF;
    step();
    check("nop_ctrl_live", 64'(out_ctrl), 64'hFF);
    in_valid = 1'b0;
    step();
    check("nop_valid", 64'(out_valid), 64'h0);
    check("nop_ctrl", 64'(out_ctrl), 64'h0);

    // Async reset mid-transfer empties the stage without a clock edge
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h77;
    step();
    in_valid = 1'b0;
    check("ar_pre_valid", 64'(out_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'h0);
    check("ar_data", 64'(out_data), 64'h0);
    check("ar_ready", 64'(in_ready), 64'h1);

    // 6. Statistics counters
    do_reset();
    check("st_rst_stall", 64'(stall_cnt), 64'h0);
    check("st_rst_bubble", 64'(bubble_cnt), 64'h0);
    step();
    step();
    step();
`ifdef PIPE_STAGE_STATS_EN
    check("st_bubble_3", 64'(bubble_cnt), 64'h3);
`else
    check("st_bubble_off", 64'(bubble_cnt), 64'h0);
`endif
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h99;
    step();
    in_valid = 1'b0;
    repeat (5) step();
`ifdef PIPE_STAGE_STATS_EN
    check("st_stall_5", 64'(stall_cnt), 64'h5);
`else
    check("st_stall_off", 64'(stall_cnt), 64'h0);
`endif
    repeat (15) step();
`ifdef PIPE_STAGE_STATS_EN
    check("st_stall_sat", 64'(stall_cnt), 64'hF);
    check("st_bubble_held", 64'(bubble_cnt), 64'h4);
`else
    check("st_stall_off_20", 64'(stall_cnt), 64'h0);
`endif
    check("st_hold_data", 64'(out_data), 64'h99);
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
    check("st_flush_keeps", 64'(stall_cnt), 64'hF);
`else
    check("st_flush_off", 64'(stall_cnt), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
